// File: rtl/rob_multi.sv
// rob_multi: parametrised reorder buffer with multi-port completion,
// multi-lane in-order retirement and mispredict-triggered squash.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   dispatch_*           allocate one entry at the tail (areg, T, Told, has_dest)
//   dispatch_ready/idx   room available / ROB tag handed to the dispatching op
//   complete_*           CDB_WIDTH completion ports (packed indices, mispred)
//   retire_*             RETIRE_WIDTH retire lanes (packed per lane)
//   squash               a retiring lane carries a mispredict; flush everything
//   count                occupied entries
module rob_multi #(
  parameter  int DEPTH        = 32,
  parameter  int RETIRE_WIDTH = 2,
  parameter  int CDB_WIDTH    = 2,
  parameter  int PREG_W       = 6,
  parameter  int AREG_W       = 5,
  localparam int IDX_W        = $clog2(DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dispatch_en,
  input  logic [AREG_W-1:0]              dispatch_areg,
  input  logic [PREG_W-1:0]              dispatch_t,
  input  logic [PREG_W-1:0]              dispatch_t_old,
  input  logic                           dispatch_has_dest,
  output logic                           dispatch_ready,
  output logic [IDX_W-1:0]               dispatch_idx,
  input  logic [CDB_WIDTH-1:0]           complete_en,
  input  logic [CDB_WIDTH*IDX_W-1:0]     complete_idx,
  input  logic [CDB_WIDTH-1:0]           complete_mispred,
  output logic [RETIRE_WIDTH-1:0]        retire_en,
  output logic [RETIRE_WIDTH*AREG_W-1:0] retire_areg,
  output logic [RETIRE_WIDTH*PREG_W-1:0] retire_t,
  output logic [RETIRE_WIDTH*PREG_W-1:0] retire_t_old,
  output logic [RETIRE_WIDTH-1:0]        retire_has_dest,
  output logic                           squash,
  output logic [IDX_W:0]                 count
);

  // Per-entry status bits (reset) and payload (no reset needed)
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  complete_q, complete_d;
  logic [DEPTH-1:0]  mispred_q, mispred_d;
  logic [AREG_W-1:0] areg_q     [DEPTH];
  logic [PREG_W-1:0] t_q        [DEPTH];
  logic [PREG_W-1:0] t_old_q    [DEPTH];
  logic              has_dest_q [DEPTH];

  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;

  logic [IDX_W-1:0]  lane_idx [RETIRE_WIDTH];
  logic [IDX_W-1:0]  cdb_idx  [CDB_WIDTH];
  logic [IDX_W:0]    retire_cnt;
  logic              dispatch_accept;
  logic              blocked;

  assign count          = count_q;
  assign dispatch_idx   = tail_q;
  assign dispatch_ready = (count_q != (IDX_W+1)'(DEPTH));
  assign dispatch_accept = dispatch_en && dispatch_ready && !squash;

  always_comb begin
    for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
      lane_idx[k] = head_q + IDX_W'(k);   // wraps naturally mod DEPTH
    end
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      cdb_idx[k] = complete_idx[k*IDX_W +: IDX_W];
    end
  end

  // Retire lanes: a lane retires only if every older lane retires too and
  // no older lane is a mispredicted branch.
  always_comb begin
    retire_en       = '0;
    retire_areg     = '0;
    retire_t        = '0;
    retire_t_old    = '0;
    retire_has_dest = '0;
    squash          = 1'b0;
    blocked         = 1'b0;
    retire_cnt      = '0;
    for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
      retire_areg[k*AREG_W +: AREG_W]  = areg_q[lane_idx[k]];
      retire_t[k*PREG_W +: PREG_W]     = t_q[lane_idx[k]];
      retire_t_old[k*PREG_W +: PREG_W] = t_old_q[lane_idx[k]];
      retire_has_dest[k]               = has_dest_q[lane_idx[k]];
      if (!blocked && valid_q[lane_idx[k]] && complete_q[lane_idx[k]]) begin
        retire_en[k] = 1'b1;
        retire_cnt   = retire_cnt + 1'b1;
        if (mispred_q[lane_idx[k]]) begin
          squash  = 1'b1;
          blocked = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  // Next state. Retire clearing is applied after completion so an entry
  // retiring this cycle never keeps stale status bits.
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    mispred_d  = mispred_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (squash) begin
      valid_d    = '0;
      complete_d = '0;
      mispred_d  = '0;
      head_d     = tail_q;
      count_d    = '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest port wins mispred
      for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
        if (complete_en[k] && valid_q[cdb_idx[k]]) begin
          complete_d[cdb_idx[k]] = 1'b1;
          mispred_d[cdb_idx[k]]  = complete_mispred[k];
        end
      end
      for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
        if (retire_en[k]) begin
          valid_d[lane_idx[k]]    = 1'b0;
          complete_d[lane_idx[k]] = 1'b0;
          mispred_d[lane_idx[k]]  = 1'b0;
        end
      end
      if (dispatch_accept) begin
        valid_d[tail_q]    = 1'b1;
        complete_d[tail_q] = 1'b0;
        mispred_d[tail_q]  = 1'b0;
        tail_d             = tail_q + 1'b1;
      end
      head_d  = head_q + retire_cnt[IDX_W-1:0];
      count_d = count_q + {{IDX_W{1'b0}}, dispatch_accept} - retire_cnt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      mispred_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      mispred_q  <= mispred_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (dispatch_accept) begin
      areg_q[tail_q]     <= dispatch_areg;
      t_q[tail_q]        <= dispatch_t;
      t_old_q[tail_q]    <= dispatch_t_old;
      has_dest_q[tail_q] <= dispatch_has_dest;
    end
  end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised reorder buffer for the R10K-style out-of-order core.
- Replaces the single-retire ROB with four generalisations: configurable depth, CDB_WIDTH completion ports, up to RETIRE_WIDTH in-order retirements per cycle, and mispredict-triggered squash.
- Sits between stage_id (dispatch), stage_ic (completion) and stage_ir (retire, free-list/arch-map update).

Parameters:
DEPTH, 32, number of entries; power of two, >=4
RETIRE_WIDTH, 2, max entries retired per cycle; 1..4
CDB_WIDTH, 2, completion ports per cycle; 1..4
PREG_W, 6, physical register tag width
AREG_W, 5, architectural register index width
(IDX_W = log2(DEPTH), derived)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
dispatch_en  in  1  allocate one entry at tail
dispatch_areg  in  AREG_W  architectural destination
dispatch_t  in  PREG_W  new physical tag T
dispatch_t_old  in  PREG_W  previous mapping Told
dispatch_has_dest  in  1  0 = no register write (store/branch)
dispatch_ready  out  1  count < DEPTH
dispatch_idx  out  IDX_W  current tail index, i.e. the ROB tag given to the dispatching instruction
complete_en  in  CDB_WIDTH  per-port completion valid
complete_idx  in  CDB_WIDTH*IDX_W  packed ROB indices, port k at bits [k*IDX_W +: IDX_W]
complete_mispred  in  CDB_WIDTH  per-port branch mispredict flag
retire_en  out  RETIRE_WIDTH  lane k retires this cycle
retire_areg  out  RETIRE_WIDTH*AREG_W  packed per lane
retire_t  out  RETIRE_WIDTH*PREG_W  packed per lane
retire_t_old  out  RETIRE_WIDTH*PREG_W  packed per lane, freed to the free list
retire_has_dest  out  RETIRE_WIDTH  packed per lane
squash  out  1  mispredicted branch retiring; flush the pipeline
count  out  IDX_W+1  occupied entries

Behaviour:
- State: per entry valid, complete, mispred, areg, t, t_old, has_dest. Registers head, tail, count.
- Reset (async): all valid/complete/mispred = 0; head = tail = count = 0. Outputs are then retire_en = 0, squash = 0, dispatch_ready = 1, dispatch_idx = 0, count = 0.
- Dispatch:
  - Accepted iff dispatch_en && dispatch_ready && !squash.
  - At the edge: entry[tail] is written with valid = 1, complete = 0, mispred = 0; tail <= tail + 1 mod DEPTH.
  - Dispatch while not ready, or during squash, is dropped with no state change.
- dispatch_ready uses the current count only. A same-cycle retire does not free a slot for a same-cycle dispatch.
- Completion:
  - Port k with complete_en[k] sets entry[idx].complete = 1 and entry[idx].mispred = complete_mispred[k] at the edge.
  - Completion to an invalid entry is ignored.
  - Two ports naming the same index: the higher k wins the mispred bit; complete is set either way.
- Retire (combinational from registered state):
  - Lane k examines entry[(head + k) mod DEPTH].
  - retire_en[k] = 1 iff lanes 0..k are all valid && complete, and no lane j < k has mispred.
  - Completion therefore becomes visible to retire one cycle after complete_en (earliest retire at edge + 1).
  - Per-lane fields show entry contents; fields of lanes not retiring are don't-care.
- Squash:
  - squash = 1 iff some retiring lane has mispred. That lane still retires (its T/Told are valid); later lanes are suppressed.
  - At the squash edge: all valid bits clear, head <= tail, count <= 0.
- Head/count update when not squashing:
  - head advances by R = popcount(retire_en), mod DEPTH; retired entries are cleared to invalid.
  - count <= count + accepted_dispatch - R.
- Wrap-around: indices are modulo DEPTH. Retire lanes wrap from DEPTH-1 to 0.
- Full: count == DEPTH → dispatch_ready = 0.
- Empty: count == 0 → retire_en = 0.
- Reset asserted mid-operation clears everything immediately, independent of clock.

Test Plan:
- Reset then idle: retire_en=0, squash=0, dispatch_ready=1, count=0 on all cycles.
- Dispatch 3 entries (T=33,34,35; Told=3,4,5); complete idx 1 then idx 0 on a later cycle.
  - Required: retire_en=2'b11 for T=33,34 exactly one cycle after idx 0 completes; count goes 3→1.
- Complete idx 2 alone before idx 0: no retire until idx 0 completes (in-order blocking).
- Dispatch DEPTH entries: dispatch_ready=0 and count=32. A further dispatch is dropped and tail is unchanged. Completing all entries drains 2 per cycle over 16 cycles, with head wrapping 31→0.
- Entries 0..3 valid, complete idx 0 with mispred=1, complete 1..3 normally.
  - Required: lane0 retires, squash=1, lane1 retire_en=0.
  - Next cycle: count=0 and head=tail=4.
- Assert reset asynchronously between edges with count=5: count=0 and retire_en=0 before the next rising edge.
